// File: rtl/seg7_reader.sv
// Reads four active-low 7-segment patterns (hex3 = MSD) back into a binary value, one digit per clock.
// Optional macro SEG7_READER_BLANK_AS_ZERO_EN: decode the blank pattern 7'b1111111 as digit 0.
module seg7_reader #(
    parameter int NUM_DIGITS = 4,
    parameter int OUT_W      = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       hex0,
    input  logic [6:0]       hex1,
    input  logic [6:0]       hex2,
    input  logic [6:0]       hex3,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] value,
    output logic             err,
    output logic [1:0]       err_digit
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {legal, bcd_digit}; patterns are {g,f,e,d,c,b,a}, active-low.
    function automatic logic [4:0] decode(input logic [6:0] pat);
        logic [4:0] r;
        case (pat)
            7'b1000000: r = 5'h10;
            7'b1111001: r = 5'h11;
            7'b0100100: r = 5'h12;
            7'b0110000: r = 5'h13;
            7'b0011001: r = 5'h14;
            7'b0010010: r = 5'h15;
            7'b0000010: r = 5'h16;
            7'b1111000: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0010000: r = 5'h19;
`ifdef SEG7_READER_BLANK_AS_ZERO_EN
            7'b1111111: r = 5'h10;
`endif
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [3:0][6:0]  snap_q, snap_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [OUT_W-1:0] value_q, value_d;
    logic             err_q, err_d;
    logic [1:0]       err_digit_q, err_digit_d;

    logic [4:0]       dec;
    logic [OUT_W-1:0] acc_next;

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        value_d     = value_q;
        err_d       = err_q;
        err_digit_d = err_digit_q;
        dec         = decode(snap_q[idx_q]);
        acc_next    = acc_q * OUT_W'(10) + OUT_W'(dec[3:0]);

        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = {hex3, hex2, hex1, hex0};
                    acc_d   = '0;
                    idx_d   = IDX_W'(NUM_DIGITS - 1);
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!dec[4]) begin
                    // First illegal digit aborts; result is forced to zero.
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    value_d     = '0;
                    err_d       = 1'b1;
                    err_digit_d = 2'(idx_q);
                end else begin
                    acc_d = acc_next;
                    if (idx_q == '0) begin
                        state_d     = DONE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        value_d     = acc_next;
                        err_d       = 1'b0;
                        err_digit_d = 2'd0;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            value_q     <= '0;
            err_q       <= 1'b0;
            err_digit_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            value_q     <= value_d;
            err_q       <= err_d;
            err_digit_q <= err_digit_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign value     = value_q;
    assign err       = err_q;
    assign err_digit = err_digit_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: vector table of full conversions plus hand-written
// sequences for snapshot isolation, held start and mid-conversion reset.
module tb_seg7_reader;

    localparam logic [6:0] C0 = 7'b1000000;
    localparam logic [6:0] C1 = 7'b1111001;
    localparam logic [6:0] C2 = 7'b0100100;
    localparam logic [6:0] C3 = 7'b0110000;
    localparam logic [6:0] C4 = 7'b0011001;
    localparam logic [6:0] C5 = 7'b0010010;
    localparam logic [6:0] C6 = 7'b0000010;
    localparam logic [6:0] C7 = 7'b1111000;
    localparam logic [6:0] C8 = 7'b0000000;
    localparam logic [6:0] C9 = 7'b0010000;
    localparam logic [6:0] BLK = 7'b1111111;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [6:0]  hex0, hex1, hex2, hex3;
    logic        busy, done, err;
    logic [13:0] value;
    logic [1:0]  err_digit;

    int checks = 0;
    int errors = 0;
    logic [13:0] exp_q[$];

    typedef struct {
        logic [6:0]  h3, h2, h1, h0;
        logic [13:0] value;
        logic        err;
        logic [1:0]  err_digit;
        int          cyc;
    } vec_t;

    vec_t vecs[10];

    seg7_reader #(.NUM_DIGITS(4), .OUT_W(14)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .busy(busy), .done(done), .value(value), .err(err), .err_digit(err_digit)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_hex(input logic [6:0] h3, input logic [6:0] h2,
                           input logic [6:0] h1, input logic [6:0] h0);
        hex3 = h3; hex2 = h2; hex1 = h1; hex0 = h0;
    endtask

    // driver: one conversion, scoreboard compares against the table entry
    task automatic run_vec(input vec_t v, input int id);
        int cyc;
        logic busy_ok;
        logic [13:0] exp_v;
        @(negedge clk);
        set_hex(v.h3, v.h2, v.h1, v.h0);
        start = 1'b1;
        exp_q.push_back(v.value);
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done) begin
                cyc = c;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        exp_v = exp_q.pop_front();
        if (cyc == 0) begin
            check($sformatf("v%0d_done_timeout", id), 0, 1);
        end else begin
            check($sformatf("v%0d_latency", id), cyc, v.cyc);
            check($sformatf("v%0d_busy_during", id), int'(busy_ok), 1);
            check($sformatf("v%0d_busy_at_done", id), int'(busy), 0);
            check($sformatf("v%0d_value", id), int'(value), int'(exp_v));
            check($sformatf("v%0d_err", id), int'(err), int'(v.err));
            if (v.err) check($sformatf("v%0d_err_digit", id), int'(err_digit), int'(v.err_digit));
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", id), int'(done), 0);
        end
    endtask

    initial begin
        int n_done;
        int d1, d2;
        logic [13:0] v_at_done;

        vecs[0] = '{C0, C1, C2, C3, 14'd123,  1'b0, 2'd0, 5};
        vecs[1] = '{C9, C9, C9, C9, 14'd9999, 1'b0, 2'd0, 5};
        vecs[2] = '{C0, C0, 7'b1010101, C0, 14'd0, 1'b1, 2'd1, 4};
        vecs[3] = '{C8, C6, C7, C5, 14'd8675, 1'b0, 2'd0, 5};
        vecs[4] = '{C0, C0, C0, C0, 14'd0,    1'b0, 2'd0, 5};
        vecs[5] = '{7'b0000001, C1, C1, C1, 14'd0, 1'b1, 2'd3, 2};
        vecs[6] = '{C5, C5, C5, 7'b1111110, 14'd0, 1'b1, 2'd0, 5};
        vecs[7] = '{C4, C0, C2, C1, 14'd4021, 1'b0, 2'd0, 5};
        vecs[8] = '{C3, 7'b0101010, C2, 7'b0101010, 14'd0, 1'b1, 2'd2, 3};
`ifdef SEG7_READER_BLANK_AS_ZERO_EN
        vecs[9] = '{BLK, BLK, C4, C2, 14'd42, 1'b0, 2'd0, 5};
`else
        vecs[9] = '{BLK, BLK, C4, C2, 14'd0,  1'b1, 2'd3, 2};
`endif

        rst_n = 1'b0;
        start = 1'b0;
        set_hex(C8, C8, C8, C8);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_value", int'(value), 0);
        check("rst_err", int'(err), 0);
        check("rst_err_digit", int'(err_digit), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // snapshot isolation and start ignored while busy
        @(negedge clk);
        set_hex(C1, C2, C3, C4);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_done = 0;
        v_at_done = '0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) hex0 = C5;
            if (c == 2) start = 1'b1;
            if (c == 3) start = 1'b0;
            if (done) begin
                n_done++;
                v_at_done = value;
            end
        end
        check("snap_done_count", n_done, 1);
        check("snap_value", int'(v_at_done), 1234);
        check("snap_value_held", int'(value), 1234);
        run_vec('{C1, C2, C3, C5, 14'd1235, 1'b0, 2'd0, 5}, 10);

        // start held high: back-to-back conversions
        @(negedge clk);
        set_hex(C7, C7, C7, C7);
        start = 1'b1;
        @(posedge clk);
        d1 = 0; d2 = 0; n_done = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (d1 == 0) d1 = c; else if (d2 == 0) d2 = c;
            end
        end
        start = 1'b0;
        check("held_done_count", n_done, 2);
        check("held_first_done", d1, 5);
        check("held_second_done", d2, 11);
        check("held_value", int'(value), 7777);
        repeat (10) @(negedge clk);

        // reset in cycle 2 of a conversion
        run_vec(vecs[3], 11);
        @(negedge clk);
        set_hex(C2, C2, C2, C2);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_value", int'(value), 0);
        check("midrst_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("midrst_no_done", n_done, 0);
        run_vec(vecs[0], 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
